// File: rtl/pool_seq_if.sv
// Handshake and address bundle between the layer controller, the pool sequencer and the pooling datapath.
// data_valid/in_pipe_en: the sequencer holds addresses in LOAD; an operand is consumed only in a cycle where data_valid=1 and abort=0.
interface pool_seq_if #(
  parameter int CHANNELS = 32,
  parameter int MAX_WIN  = 3
);
  localparam int EL_W = $clog2(MAX_WIN * MAX_WIN);
  localparam int CH_W = $clog2(CHANNELS);

  logic            start_pool;
  logic            pool_mode;
  logic [1:0]      win_dim;
  logic [CH_W:0]   num_ch;
  logic            data_valid;
  logic            abort;
  logic [EL_W-1:0] elem_addr;
  logic [CH_W-1:0] ch_addr;
  logic            addr_valid;
  logic            in_pipe_en;
  logic            out_pipe_en;
  logic            max_avg;
  logic [3:0]      win_elems;
  logic            busy;
  logic            done;
  logic            cfg_err;
  logic [2:0]      state_dbg;

  modport master (
    output start_pool, pool_mode, win_dim, num_ch, data_valid, abort,
    input  elem_addr, ch_addr, addr_valid, in_pipe_en, out_pipe_en,
    input  max_avg, win_elems, busy, done, cfg_err, state_dbg
  );

  modport slave (
    input  start_pool, pool_mode, win_dim, num_ch, data_valid, abort,
    output elem_addr, ch_addr, addr_valid, in_pipe_en, out_pipe_en,
    output max_avg, win_elems, busy, done, cfg_err, state_dbg
  );
endinterface

// File: rtl/pool_seq_ctrl.sv
// Pooling sequencer: walks a KxK window per channel, waits for each operand, drains one
// pooled result per channel, and pulses done after the last channel.
module pool_seq_ctrl #(
  parameter int CHANNELS = 32,
  parameter int MAX_WIN  = 3
) (
  input  logic     clk,
  input  logic     nrst,
  pool_seq_if.slave bus
);
  localparam int EL_W = $clog2(MAX_WIN * MAX_WIN);
  localparam int CH_W = $clog2(CHANNELS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [EL_W-1:0] elem_q, elem_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [EL_W-1:0] last_elem_q, last_elem_d;
  logic [CH_W-1:0] last_ch_q, last_ch_d;
  logic            max_avg_q, max_avg_d;
  logic [3:0]      win_elems_q, win_elems_d;
  logic            cfg_err_q, cfg_err_d;

  logic cfg_ok;
  logic job_active;

  assign cfg_ok = (int'(bus.win_dim) >= 2) && (int'(bus.win_dim) <= MAX_WIN) &&
                  (int'(bus.num_ch) >= 1) && (int'(bus.num_ch) <= CHANNELS);
  assign job_active = (state_q == S_ADDR) || (state_q == S_LOAD) || (state_q == S_DRAIN);

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    ch_d        = ch_q;
    last_elem_d = last_elem_q;
    last_ch_d   = last_ch_q;
    max_avg_d   = max_avg_q;
    win_elems_d = win_elems_q;
    cfg_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_pool) begin
          if (cfg_ok) begin
            max_avg_d   = bus.pool_mode;
            win_elems_d = 4'(int'(bus.win_dim) * int'(bus.win_dim));
            last_elem_d = EL_W'(int'(bus.win_dim) * int'(bus.win_dim) - 1);
            last_ch_d   = CH_W'(int'(bus.num_ch) - 1);
            elem_d      = '0;
            ch_d        = '0;
            state_d     = S_ADDR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_ADDR: state_d = S_LOAD;
      S_LOAD: begin
        if (bus.data_valid) begin
          if (elem_q == last_elem_q) begin
            elem_d  = '0;
            state_d = S_DRAIN;
          end else begin
            elem_d  = elem_q + EL_W'(1);
            state_d = S_ADDR;
          end
        end
      end
      S_DRAIN: begin
        if (ch_q == last_ch_q) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_ADDR;
        end
      end
      S_DONE: begin
        ch_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any data_valid or drain progress in the same cycle.
    if (bus.abort && job_active) begin
      state_d = S_IDLE;
      elem_d  = '0;
      ch_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      ch_q        <= '0;
      last_elem_q <= '0;
      last_ch_q   <= '0;
      max_avg_q   <= 1'b0;
      win_elems_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      ch_q        <= ch_d;
      last_elem_q <= last_elem_d;
      last_ch_q   <= last_ch_d;
      max_avg_q   <= max_avg_d;
      win_elems_q <= win_elems_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.elem_addr   = elem_q;
  assign bus.ch_addr     = ch_q;
  assign bus.addr_valid  = (state_q == S_ADDR);
  assign bus.in_pipe_en  = (state_q == S_LOAD) && bus.data_valid && !bus.abort;
  assign bus.out_pipe_en = (state_q == S_DRAIN) && !bus.abort;
  assign bus.max_avg     = max_avg_q;
  assign bus.win_elems   = win_elems_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.cfg_err     = cfg_err_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Bench for pool_seq_ctrl: a job-level model queues the expected enable/done/cfg_err events,
// and a monitor pops and compares them whenever the DUT raises one.
module tb_pool_seq_ctrl;
  localparam int CHANNELS = 32;
  localparam int MAX_WIN  = 3;
  localparam int EV_W     = 16;
  localparam int T_LOAD   = 0;
  localparam int T_DRAIN  = 1;
  localparam int T_DONE   = 2;
  localparam int T_CFG    = 3;
  localparam int ST_LOAD  = 2;
  localparam int ST_DRAIN = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  pool_seq_if #(.CHANNELS(CHANNELS), .MAX_WIN(MAX_WIN)) bus();

  pool_seq_ctrl #(.CHANNELS(CHANNELS), .MAX_WIN(MAX_WIN)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  logic [EV_W-1:0] exp_q[$];
  int              lat_q[$];
  int              n_checks   = 0;
  int              n_fail     = 0;
  int              cyc        = 0;
  int              start_cyc  = 0;
  logic            prev_busy  = 1'b0;
  bit              model_mode = 1'b0;
  int              model_we   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=timeout expected=event (t=%0t)", name, $time);
  endtask

  function automatic logic [EV_W-1:0] ev(input int t, input int c, input int e, input bit m, input int we);
    return {2'(t), 5'(c), 4'(e), m, 4'(we)};
  endfunction

  // ---------------- monitor ----------------
  task automatic observe(input int t);
    logic [EV_W-1:0] act;
    logic [EV_W-1:0] exp;
    if (t == T_LOAD || t == T_DRAIN)
      act = ev(t, int'(bus.ch_addr), int'(bus.elem_addr), bus.max_avg, int'(bus.win_elems));
    else
      act = ev(t, 0, 0, bus.max_avg, int'(bus.win_elems));
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: actual=%0h expected=none (t=%0t)", act, $time);
    end else begin
      exp = exp_q.pop_front();
      chk("event", int'(act), int'(exp));
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!nrst) begin
      prev_busy = 1'b0;
    end else begin
      if (bus.busy && !prev_busy) start_cyc = cyc;
      prev_busy = bus.busy;
      chk("pipe_en_exclusive", int'(bus.in_pipe_en & bus.out_pipe_en), 0);
      if (bus.cfg_err)     observe(T_CFG);
      if (bus.in_pipe_en)  observe(T_LOAD);
      if (bus.out_pipe_en) observe(T_DRAIN);
      if (bus.done) begin
        observe(T_DONE);
        if (lat_q.size() == 0) fail_now("latency_entry");
        else begin
          int lat;
          lat = lat_q.pop_front();
          if (lat >= 0) chk("job_latency", cyc - start_cyc + 1, lat);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_model(input bit mode, input int k, input int n, input int lat);
    for (int c = 0; c < n; c++) begin
      for (int e = 0; e < k * k; e++) exp_q.push_back(ev(T_LOAD, c, e, mode, k * k));
      exp_q.push_back(ev(T_DRAIN, c, 0, mode, k * k));
    end
    exp_q.push_back(ev(T_DONE, 0, 0, mode, k * k));
    lat_q.push_back(lat);
    model_mode = mode;
    model_we   = k * k;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_start(input bit mode, input int k, input int n);
    @(posedge clk); #1;
    bus.start_pool = 1'b1;
    bus.pool_mode  = mode;
    bus.win_dim    = 2'(k);
    bus.num_ch     = 6'(n);
    @(posedge clk); #1;
    bus.start_pool = 1'b0;
  endtask

  task automatic start_job(input bit mode, input int k, input int n, input int lat);
    push_model(mode, k, n, lat);
    drive_start(mode, k, n);
  endtask

  task automatic finish_job(input bit rand_dv, input bit busy_starts);
    bit seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else begin
        bus.data_valid = rand_dv ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (busy_starts && $urandom_range(0, 5) == 0) begin
          bus.start_pool = 1'b1;
          bus.pool_mode  = ~model_mode;
          bus.win_dim    = 2'd2;
          bus.num_ch     = 6'd1;
        end else begin
          bus.start_pool = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    bus.start_pool = 1'b0;
    bus.data_valid = 1'b0;
    if (!seen) fail_now("job_done");
    @(posedge clk); #1;
  endtask

  task automatic run_job(input bit mode, input int k, input int n, input bit rand_dv, input bit busy_starts);
    start_job(mode, k, n, rand_dv ? -1 : n * (2 * k * k + 1) + 1);
    finish_job(rand_dv, busy_starts);
  endtask

  task automatic cfg_reject(input int k, input int n);
    exp_q.push_back(ev(T_CFG, 0, 0, model_mode, model_we));
    drive_start(1'b1, k, n);
    chk("cfg_err_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    chk("cfg_err_still_idle", int'(bus.busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},       int'(bus.busy), 0);
    chk({tag, "_done"},       int'(bus.done), 0);
    chk({tag, "_addr_valid"}, int'(bus.addr_valid), 0);
    chk({tag, "_in_pipe_en"}, int'(bus.in_pipe_en), 0);
    chk({tag, "_out_pipe_en"},int'(bus.out_pipe_en), 0);
    chk({tag, "_max_avg"},    int'(bus.max_avg), 0);
    chk({tag, "_win_elems"},  int'(bus.win_elems), 0);
    chk({tag, "_cfg_err"},    int'(bus.cfg_err), 0);
    chk({tag, "_elem_addr"},  int'(bus.elem_addr), 0);
    chk({tag, "_ch_addr"},    int'(bus.ch_addr), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    int stalls;
    bus.start_pool = 1'b0;
    bus.pool_mode  = 1'b0;
    bus.win_dim    = 2'd0;
    bus.num_ch     = 6'd0;
    bus.data_valid = 1'b0;
    bus.abort      = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_all_zero("post_reset");

    // basic jobs
    run_job(1'b1, 2, 1, 1'b0, 1'b0);
    run_job(1'b0, 3, 2, 1'b0, 1'b0);

    // five-cycle operand stall at element 2
    start_job(1'b0, 2, 1, 15);
    bus.data_valid = 1'b1;
    stalls = 0;
    found  = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.done) found = 1'b1;
      else begin
        if (stalls == 0 && int'(bus.state_dbg) == ST_LOAD && bus.elem_addr == 4'd2) begin
          bus.data_valid = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            chk("stall_elem_held", int'(bus.elem_addr), 2);
            chk("stall_in_load", int'(bus.state_dbg), ST_LOAD);
          end
          stalls = 5;
        end
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    bus.data_valid = 1'b0;
    chk("stall_applied", stalls, 5);
    if (!found) fail_now("stall_job_done");
    @(posedge clk); #1;

    // illegal configurations
    cfg_reject(1, 1);
    cfg_reject(2, 0);
    cfg_reject(2, 33);
    cfg_reject($urandom_range(0, 1), $urandom_range(1, 32));
    cfg_reject(3, $urandom_range(34, 63));

    // abort in LOAD of channel 1, then a clean restart
    start_job(1'b1, 3, 4, -1);
    bus.data_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (int'(bus.state_dbg) == ST_LOAD && bus.ch_addr == 5'd1 && bus.elem_addr == 4'd4) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!found) fail_now("abort_target");
    bus.abort = 1'b1;
    #1;
    chk("abort_no_in_pipe_en", int'(bus.in_pipe_en), 0);
    chk("abort_events_left", exp_q.size(), 41 - 14);
    @(posedge clk); #1;
    bus.abort      = 1'b0;
    bus.data_valid = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ch_clear", int'(bus.ch_addr), 0);
    chk("abort_elem_clear", int'(bus.elem_addr), 0);
    exp_q.delete();
    void'(lat_q.pop_back());
    repeat (3) @(posedge clk); #1;
    chk("abort_no_done", int'(bus.done), 0);
    run_job(1'b0, 2, 2, 1'b0, 1'b0);

    // full channel count with busy-time start requests
    run_job(1'($urandom_range(0, 1)), 2, CHANNELS, 1'b0, 1'b1);

    // randomized jobs
    for (int j = 0; j < 6; j++) begin
      run_job(1'($urandom_range(0, 1)), $urandom_range(2, 3), $urandom_range(1, 5),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a drain
    start_job(1'b1, 3, 2, -1);
    bus.data_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (int'(bus.state_dbg) == ST_DRAIN) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!found) fail_now("drain_target");
    #1;
    nrst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    void'(lat_q.pop_back());
    model_mode = 1'b0;
    model_we   = 0;
    bus.data_valid = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("after_reset_idle", int'(bus.busy), 0);
    run_job(1'b0, 3, 1, 1'b0, 1'b1);

    repeat (5) @(posedge clk); #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("lat_q_drained", lat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
